// File: rtl/inference_pkg.sv
// Shared constants and types for the inference host: wrapper opcodes, wrapper status codes,
// the host FSM states and the bit layout of the info command word.
package inference_pkg;

   localparam logic [1:0] OP_IDLE  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_INFO  = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int INFO_READ_LSB  = 0;
   localparam int INFO_COUNT_LSB = 10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_INFO   = 3'd2,
      S_WAIT   = 3'd3,
      S_RESULT = 3'd4
   } state_t;

endpackage

// File: rtl/inference_host_info_pack.sv
// info_pack: packs the read and count window lengths into the wrapper's info data word;
// every bit outside the two length fields is zero.
module info_pack
   import inference_pkg::*;
#(
   parameter int DATA_W = 19,
   parameter int LEN_W  = 8
) (
   input  logic [LEN_W-1:0]  i_read_len,
   input  logic [LEN_W-1:0]  i_count_len,
   output logic [DATA_W-1:0] o_info
);

   // Place both length fields into an otherwise zero word
   always_comb begin
      o_info = '0;
      o_info[INFO_READ_LSB +: LEN_W]  = i_read_len;
      o_info[INFO_COUNT_LSB +: LEN_W] = i_count_len;
   end

endmodule

// File: rtl/inference_host.sv
// inference_host: streams a frame into the SNN wrapper, issues the info command, waits for the
// count window to finish and returns the result. Define INFERENCE_HOST_STATS_EN for frames_o.
module inference_host
   import inference_pkg::*;
#(
   parameter int DATA_W = 19,
   parameter int DEPTH  = 128,
   parameter int LEN_W  = 8,
   parameter int RES_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_last_i,
   input  logic [LEN_W-1:0]  read_len_i,
   input  logic [LEN_W-1:0]  count_len_i,
   output logic [1:0]        opcode_o,
   output logic [DATA_W-1:0] data_o,
   input  logic [1:0]        status_i,
   input  logic [RES_W-1:0]  result_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [RES_W-1:0]  res_data_o,
   output logic              res_settled_o,
   output logic              overflow_o
`ifdef INFERENCE_HOST_STATS_EN
   ,
   output logic [15:0]       frames_o
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [LEN_W-1:0]    r_read_len;
   logic [LEN_W-1:0]    r_count_len;
   logic                r_wait_first;
   logic [1:0]          r_opcode;
   logic [DATA_W-1:0]   r_data;
   logic                r_res_valid;
   logic [RES_W-1:0]    r_res_data;
   logic                r_res_settled;
   logic                r_overflow;
   logic [DATA_W-1:0]   w_info;
   logic                w_accept;
   logic                w_frame_end;
   logic                w_info_go;
   logic                w_capture;
   logic                w_handshake;
   logic                w_cnt_full;

   info_pack #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_info_pack (
      .i_read_len  (r_read_len),
      .i_count_len (r_count_len),
      .o_info      (w_info)
   );

   assign w_cnt_full = (r_cnt == CNT_W'(DEPTH - 1));
   assign s_ready_o  = (r_state == S_IDLE) || (r_state == S_LOAD);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-cycle event decode
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_frame_end = 1'b0;
      w_info_go   = 1'b0;
      w_capture   = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         S_IDLE, S_LOAD: begin
            if (s_valid_i) begin
               w_accept = 1'b1;
               if (s_last_i || w_cnt_full) begin
                  w_frame_end = 1'b1;
                  w_next      = S_INFO;
               end else begin
                  w_next = S_LOAD;
               end
            end else begin
               w_next = r_state;
            end
         end
         // The wrapper drops info commands while it is still counting
         S_INFO: begin
            if (status_i != ST_BUSY) begin
               w_info_go = 1'b1;
               w_next    = S_WAIT;
            end else begin
               w_next = S_INFO;
            end
         end
         S_WAIT: begin
            if (!r_wait_first && (status_i != ST_BUSY)) begin
               w_capture = 1'b1;
               w_next    = S_RESULT;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_RESULT: begin
            if (res_ready_i) begin
               w_handshake = 1'b1;
               w_next      = S_IDLE;
            end else begin
               w_next = S_RESULT;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Command outputs, frame bookkeeping and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt         <= '0;
         r_read_len    <= '0;
         r_count_len   <= '0;
         r_wait_first  <= 1'b0;
         r_opcode      <= OP_IDLE;
         r_data        <= '0;
         r_res_valid   <= 1'b0;
         r_res_data    <= '0;
         r_res_settled <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_opcode     <= OP_IDLE;
         r_data       <= '0;
         // Status seen during the info cycle predates the wrapper reacting to it
         r_wait_first <= w_info_go;
         if (w_accept) begin
            r_opcode <= OP_WRITE;
            r_data   <= s_data_i;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
         if (w_frame_end) begin
            r_cnt       <= '0;
            r_read_len  <= read_len_i;
            r_count_len <= count_len_i;
            if (!s_last_i) begin
               r_overflow <= 1'b1;
            end
         end
         if (w_info_go) begin
            r_opcode <= OP_INFO;
            r_data   <= w_info;
         end
         if (w_capture) begin
            r_res_valid   <= 1'b1;
            r_res_data    <= result_i;
            r_res_settled <= (status_i == ST_DONE);
         end
         if (w_handshake) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign opcode_o      = r_opcode;
   assign data_o        = r_data;
   assign res_valid_o   = r_res_valid;
   assign res_data_o    = r_res_data;
   assign res_settled_o = r_res_settled;
   assign overflow_o    = r_overflow;

`ifdef INFERENCE_HOST_STATS_EN
   logic [15:0] r_frames;

   // Completed result handshakes, wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frames <= 16'd0;
      end else if (w_handshake) begin
         r_frames <= r_frames + 16'd1;
      end else begin
         r_frames <= r_frames;
      end
   end

   assign frames_o = r_frames;
`endif

endmodule

// File: tb/tb_inference_host.sv
// Bench for inference_host: table of frames plus hand-written stall, hold, overflow and reset
// sequences, with a behavioural wrapper model and command/result scoreboards.
module tb_inference_host;
   import inference_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid_i, s_ready_o, s_last_i;
   logic [18:0] s_data_i;
   logic [7:0]  read_len_i, count_len_i;
   logic [1:0]  opcode_o, status_i;
   logic [18:0] data_o;
   logic [3:0]  result_i, res_data_o;
   logic        res_valid_o, res_ready_i, res_settled_o, overflow_o;
`ifdef INFERENCE_HOST_STATS_EN
   logic [15:0] frames_o;
`endif

   inference_host dut (
      .clk(clk), .rst(rst),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
      .read_len_i(read_len_i), .count_len_i(count_len_i),
      .opcode_o(opcode_o), .data_o(data_o), .status_i(status_i), .result_i(result_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .res_settled_o(res_settled_o), .overflow_o(overflow_o)
`ifdef INFERENCE_HOST_STATS_EN
      , .frames_o(frames_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Wrapper model: busy for (read+count) mod 256 cycles after the info edge, then idle-with-result
   logic [1:0] wr_status;
   logic [7:0] wr_timer, wr_sum;
   logic       st_ovr_en;
   logic [1:0] st_ovr_val;
   assign wr_sum   = data_o[7:0] + data_o[17:10];
   assign status_i = st_ovr_en ? st_ovr_val : wr_status;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_status <= ST_IDLE;
         wr_timer  <= 8'd0;
      end else if (opcode_o == OP_INFO) begin
         wr_timer  <= wr_sum;
         wr_status <= (wr_sum == 8'd0) ? ST_IDLE : ST_BUSY;
      end else if (wr_timer > 8'd1) begin
         wr_timer <= wr_timer - 8'd1;
      end else if (wr_timer == 8'd1) begin
         wr_timer  <= 8'd0;
         wr_status <= ST_DONE;
      end
   end

   always @(posedge clk) cyc++;

   typedef struct packed { logic [1:0] op; logic [18:0] data; } cmd_t;
   typedef struct { logic [3:0] res; logic settled; int lat; } res_t;
   cmd_t exp_cmd_q[$];
   res_t exp_res_q[$];
   int   info_cyc = 0;
   logic prev_rv = 1'b0;

   // Scoreboard monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         prev_rv = 1'b0;
      end else begin
         if (opcode_o != OP_IDLE) begin
            if (exp_cmd_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL cmd_unexpected: got op %0d data 0x%0h, none expected (cycle %0d)",
                        opcode_o, data_o, cyc);
            end else begin
               cmd_t e;
               e = exp_cmd_q.pop_front();
               check("cmd", 32'({opcode_o, data_o}), 32'(e));
            end
            if (opcode_o == OP_INFO) info_cyc = cyc;
         end
         if (res_valid_o && !prev_rv) begin
            if (exp_res_q.size() == 0) fail_now("res_unexpected");
            else if (exp_res_q[0].lat >= 0) check("latency", 32'(cyc - info_cyc), 32'(exp_res_q[0].lat));
         end
         if (res_valid_o && res_ready_i && exp_res_q.size() != 0) begin
            res_t r;
            r = exp_res_q.pop_front();
            check("res_data", 32'(res_data_o), 32'(r.res));
            check("res_settled", 32'(res_settled_o), 32'(r.settled));
         end
         prev_rv = res_valid_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n, input logic [18:0] base, input logic [7:0] rl,
                             input logic [7:0] cl, input logic last_on_final);
      logic [18:0] w;
      int guard;
      for (int i = 0; i < n; i++) begin
         w = 19'(base * (i + 1));
         s_valid_i = 1'b1; s_data_i = w; s_last_i = last_on_final && (i == n - 1);
         read_len_i = rl; count_len_i = cl;
         exp_cmd_q.push_back({OP_WRITE, w});
         guard = 0;
         while (!s_ready_o && guard < 200) begin tick(); guard++; end
         if (guard >= 200) fail_now("accept_timeout");
         tick();
      end
      s_valid_i = 1'b0; s_last_i = 1'b0;
      exp_cmd_q.push_back({OP_INFO, 19'(rl) | (19'(cl) << 10)});
   endtask

   task automatic wait_result(input logic busy_check);
      int guard = 0;
      while (!(res_valid_o && res_ready_i) && guard < 600) begin
         if (busy_check) check("no_accept_busy", 32'(s_ready_o), 32'd0);
         tick();
         guard++;
      end
      if (guard >= 600) fail_now("result_timeout");
      s_valid_i = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_opcode"}, 32'(opcode_o), 32'(OP_IDLE));
      check({tag, "_data"}, 32'(data_o), 32'd0);
      check({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
      check({tag, "_res_data"}, 32'(res_data_o), 32'd0);
      check({tag, "_settled"}, 32'(res_settled_o), 32'd0);
      check({tag, "_overflow"}, 32'(overflow_o), 32'd0);
      check({tag, "_s_ready"}, 32'(s_ready_o), 32'd1);
   endtask

   typedef struct {
      int n; logic [18:0] base; logic [7:0] rl; logic [7:0] cl;
      logic [3:0] res; logic settled; int lat;
   } vec_t;
   vec_t tbl[5];

   task automatic run_vec(input vec_t v);
      result_i = v.res;
      res_ready_i = 1'b1;
      exp_res_q.push_back('{v.res, v.settled, v.lat});
      send_frame(v.n, v.base, v.rl, v.cl, 1'b1);
      wait_result(1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "global timeout");
   end

   initial begin
      tbl[0] = '{3, 19'h00011, 8'd5,   8'd10,  4'h9, 1'b1, 17};
      tbl[1] = '{1, 19'h7FFFF, 8'd0,   8'd0,   4'h3, 1'b0, 2};
      tbl[2] = '{2, 19'h40001, 8'd200, 8'd100, 4'hA, 1'b1, 46};
      tbl[3] = '{4, 19'h00005, 8'd255, 8'd1,   4'h5, 1'b0, 2};
      tbl[4] = '{1, 19'h2AAAA, 8'd1,   8'd0,   4'hF, 1'b1, 3};

      rst = 1'b1; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = 19'd0;
      read_len_i = 8'd0; count_len_i = 8'd0; result_i = 4'd0; res_ready_i = 1'b1;
      st_ovr_en = 1'b0; st_ovr_val = ST_IDLE;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_vec(tbl[i]);

      // Info held off while the wrapper reports busy
      st_ovr_en = 1'b1; st_ovr_val = ST_BUSY; result_i = 4'h6;
      exp_res_q.push_back('{4'h6, 1'b1, 7});
      send_frame(1, 19'h00123, 8'd2, 8'd3, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_opcode", 32'(opcode_o), 32'(OP_IDLE));
         check("stall_s_ready", 32'(s_ready_o), 32'd0);
      end
      st_ovr_en = 1'b0;
      tick();
      check("info_after_stall", 32'(opcode_o), 32'(OP_INFO));
      wait_result(1'b0);

      // Result held while the consumer is not ready
      res_ready_i = 1'b0; result_i = 4'hC;
      exp_res_q.push_back('{4'hC, 1'b1, 4});
      send_frame(2, 19'h00031, 8'd1, 8'd1, 1'b1);
      for (int g = 0; g < 100 && !res_valid_o; g++) tick();
      result_i = 4'h0;
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", 32'(res_valid_o), 32'd1);
         check("hold_data", 32'(res_data_o), 32'hC);
         check("hold_s_ready", 32'(s_ready_o), 32'd0);
         tick();
      end
      res_ready_i = 1'b1; result_i = 4'h7;
      s_valid_i = 1'b1; s_data_i = 19'h00155; s_last_i = 1'b1;
      read_len_i = 8'd0; count_len_i = 8'd0;
      check("handshake_s_ready", 32'(s_ready_o), 32'd0);
      exp_cmd_q.push_back({OP_WRITE, 19'h00155});
      exp_cmd_q.push_back({OP_INFO, 19'h00000});
      exp_res_q.push_back('{4'h7, 1'b0, 2});
      tick();
      check("after_hs_s_ready", 32'(s_ready_o), 32'd1);
      check("after_hs_valid", 32'(res_valid_o), 32'd0);
      tick();
      s_valid_i = 1'b0; s_last_i = 1'b0;
      check("next_frame_write", 32'(opcode_o), 32'(OP_WRITE));
      wait_result(1'b0);

      // DEPTH words without a last marker
      result_i = 4'h2;
      check("overflow_before", 32'(overflow_o), 32'd0);
      exp_res_q.push_back('{4'h2, 1'b1, 9});
      send_frame(128, 19'h00001, 8'd3, 8'd4, 1'b0);
      check("overflow_set", 32'(overflow_o), 32'd1);
      s_valid_i = 1'b1; s_data_i = 19'h7ABCD; s_last_i = 1'b1;
      wait_result(1'b1);
      s_last_i = 1'b0;
      check("overflow_sticky", 32'(overflow_o), 32'd1);

      // Reset while waiting for the count window
      result_i = 4'h4;
      exp_res_q.push_back('{4'h4, 1'b1, -1});
      send_frame(1, 19'h00099, 8'd40, 8'd10, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      exp_cmd_q.delete();
      exp_res_q.delete();
      check_reset_outputs("midwait_rst");
`ifdef INFERENCE_HOST_STATS_EN
      check("frames_reset", 32'(frames_o), 32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      run_vec(tbl[0]);
`ifdef INFERENCE_HOST_STATS_EN
      check("frames_count", 32'(frames_o), 32'd1);
`endif

      tick(); tick();
      check("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
      check("res_q_drained", 32'(exp_res_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inference_host.md
# inference_host

Host-side command sequencer that drives the SNN inference wrapper's opcode/data/status interface. It accepts a frame of 19-bit input words over a valid/ready stream and issues one write command per word. It then issues the info command carrying the read and count lengths, tracks the wrapper's status until the count window ends, and returns the 4-bit result over a valid/ready handshake. It sits between the system-side sample source and the wrapper, one instance per wrapper.

## Interface
- DATA_W, 19: width of a frame word and of the wrapper data bus
- DEPTH, 128: wrapper memory depth; maximum words per frame
- LEN_W, 8: width of read_len_i and count_len_i
- RES_W, 4: result width
- clk  in  1  single clock. Reset is asynchronous and active-high.
- rst  in  1  asynchronous reset, active-high
- s_valid_i  in  1  frame word valid
- s_ready_o  out  1  frame word accepted when valid and ready are both high
- s_data_i  in  DATA_W  frame word
- s_last_i  in  1  marks the last word of a frame
- read_len_i  in  LEN_W  read window; sampled with the last word
- count_len_i  in  LEN_W  count window; sampled with the last word
- opcode_o  out  2  to wrapper: 0 idle, 1 write, 2 info
- data_o  out  DATA_W  to wrapper data bus
- status_i  in  2  from wrapper: 0 idle, 1 busy, 2 idle with result
- result_i  in  RES_W  from wrapper
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- res_data_o  out  RES_W  captured result
- res_settled_o  out  1  1 if status_i was 2 at capture
- overflow_o  out  1  sticky; frame was truncated at DEPTH words

## Operation
- The FSM has these states: IDLE, LOAD, INFO, WAIT, RESULT.
- s_ready_o is 1 only in IDLE and LOAD.
- IDLE/LOAD accept: the next cycle drives opcode_o=1 and data_o=s_data_i. A 1-bit-wider word counter increments. IDLE moves to LOAD.
- Frame end is an accept with s_last_i=1, or the DEPTH-th accepted word.
  - If the DEPTH-th word arrives without s_last_i, set overflow_o.
  - At frame end, latch read_len_i and count_len_i, clear the word counter, and go to INFO.
- No accept: opcode_o=0 and data_o=0.
- INFO: wait while status_i==1, because the wrapper ignores info while counting. Otherwise drive for exactly one cycle:
  - opcode_o=2
  - data_o[7:0]=read_len
  - data_o[17:10]=count_len
  - all other bits 0
  - Then go to WAIT.
- WAIT:
  - Ignore status_i in the first cycle after the info cycle, because the wrapper's timers update on that edge.
  - From the second cycle onward, status_i==1 keeps the FSM in WAIT.
  - Any other status_i value captures res_data_o=result_i and res_settled_o=(status_i==2), then goes to RESULT.
- Window sum: the wrapper loads an 8-bit (read_len+count_len) mod 256. A sum of 0 never shows busy, so the result is captured on the first evaluated WAIT cycle.
- RESULT: res_valid_o=1, and captured values are held until res_ready_i. The handshake cycle returns the FSM to IDLE. No new word is accepted in that same cycle.
- overflow_o clears only on reset.

## Timing
- Reset values:
  - FSM in IDLE
  - opcode_o=0, data_o=0
  - res_valid_o=0, res_data_o=0, res_settled_o=0
  - overflow_o=0
  - s_ready_o=1
- Reset mid-frame or mid-wait abandons the frame. No partial info is ever issued.
- opcode_o and data_o are registered. Command latency is 1 cycle from accept.
- Back-to-back accepts produce back-to-back write cycles. Throughput is 1 word per cycle.
- The info cycle follows the last write cycle directly when status_i!=1.
- Result latency from the info cycle is (read_len+count_len) mod 256 + 2 cycles, given a wrapper that goes busy on the following edge.

## Configuration
- INFERENCE_HOST_STATS_EN defined: adds output frames_o[15:0], a wrapping count of completed result handshakes, reset to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package inference_pkg holds:
  - opcode constants OP_IDLE=0, OP_WRITE=1, OP_INFO=2
  - status constants ST_IDLE=0, ST_BUSY=1, ST_DONE=2
  - the FSM state enum
  - the info-word bit positions: read [7:0], count [17:10]
- One sub-module, info_pack, builds the info data word from read_len and count_len.

## Test plan
- 3 words 0x00011, 0x00022, 0x00033 (last on third), read_len=5, count_len=10, wrapper model busy 15 cycles → opcode_o sequence 1,1,1,2; info data_o=0x02805; capture after busy drops; res_data_o=result_i, res_settled_o=1.
- 128 words without s_last_i → overflow_o=1 after word 128; info issued; the 129th word is not accepted before the result handshake.
- read_len=0, count_len=0 → info data_o=0; result captured 2 cycles after info; status 0 gives res_settled_o=0.
- status_i held at 1 at frame end → INFO stalls with opcode_o=0; info issued the cycle after status_i leaves 1.
- res_ready_i low for 10 cycles → res_valid_o and res_data_o stable; s_ready_o=0 throughout; s_ready_o=1 the cycle after the handshake.
- rst pulsed during WAIT → all outputs at reset values immediately; the next frame runs normally.
